// File: rtl/param_data_memory.sv
// Byte-lane data memory with a power-on clear sweep.
// One read or write per cycle once the sweep has zeroed every word.
module param_data_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [DATA_WIDTH-1:0]   data_inputs,
  output logic [DATA_WIDTH-1:0]   data_outputs,
  output logic                    data_valid,
  output logic                    ready,
  output logic                    addr_error
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         clr_q, clr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dv_q, dv_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic [PW-1:0]         idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic                  mem_we;
  logic [PW-1:0]         mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;

  assign ready    = (state_q == IDLE);
  assign accept   = ready & (read | write);
  assign in_range = {1'b0, address} < DEPTH_W;
  assign idx      = in_range ? address[PW-1:0] : '0;
  assign rd_word  = mem[idx];

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) begin
        merged[8*i +: 8] = data_inputs[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    mem_we  = 1'b0;
    mem_wa  = idx;
    mem_wd  = merged;
    unique case (1'b1)
      state_q == CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_q;
        mem_wd = '0;
        if (clr_q == LAST) begin
          state_d = IDLE;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      state_q == IDLE: begin
        mem_we = accept & write & in_range;
      end
      default: ;
    endcase
  end

  // Write-first: a combined read/write returns the merged word.
  always_comb begin
    dv_d   = accept & read;
    err_d  = accept & ~in_range;
    dout_d = dout_q;
    if (accept && read) begin
      if (!in_range) begin
        dout_d = '0;
      end else if (write) begin
        dout_d = merged;
      end else begin
        dout_d = rd_word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign data_outputs = dout_q;
  assign data_valid   = dv_q;
  assign addr_error   = err_q;

endmodule
